// File: rtl/updown_tick_counter.sv
// Up/down modulo counter with tick prescaler, synchronous load and a double-dabble BCD image.
// Define COUNTER_BCD_EN to build the BCD converter; otherwise BCD and BCD_VALID are tied low.
module updown_tick_counter #(
   parameter int WIDTH  = 19,
   parameter int MAX    = 262143,
   parameter int DIV    = 50000000,
   parameter int DIGITS = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  EN,
   input  logic                  DIR,
   input  logic                  LOAD,
   input  logic [WIDTH-1:0]      LOAD_VAL,
   output logic [WIDTH-1:0]      OUT,
   output logic                  TICK,
   output logic                  TC,
   output logic [4*DIGITS-1:0]   BCD,
   output logic                  BCD_VALID
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0]    PC_LAST = PW'(DIV - 1);
   localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);

   logic [PW-1:0] pc;

   // Free-running prescaler, independent of EN and LOAD
   always_ff @(posedge CLK) begin
      if (!RST)                pc <= '0;
      else if (pc == PC_LAST)  pc <= '0;
      else                     pc <= pc + 1'b1;
   end

   assign TICK = (pc == PC_LAST);

   always_ff @(posedge CLK) begin
      if (!RST) begin
         OUT <= DIR ? MAX_V : '0;
         TC  <= 1'b0;
      end else if (LOAD) begin
         OUT <= (LOAD_VAL > MAX_V) ? MAX_V : LOAD_VAL;
         TC  <= 1'b0;
      end else if (TICK && EN) begin
         if (!DIR) begin
            OUT <= (OUT == MAX_V) ? '0 : OUT + 1'b1;
            TC  <= (OUT == MAX_V);
         end else begin
            OUT <= (OUT == '0) ? MAX_V : OUT - 1'b1;
            TC  <= (OUT == '0);
         end
      end else begin
         TC  <= 1'b0;
      end
   end

`ifdef COUNTER_BCD_EN
   localparam int CW = $clog2(WIDTH + 1);
   localparam int SW = 4 * DIGITS;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t          state;
   logic [WIDTH-1:0] snap;
   logic [WIDTH-1:0] shreg;
   logic [SW-1:0]    scratch;
   logic [SW-1:0]    adj;
   logic [SW-1:0]    next_scratch;
   logic [CW-1:0]    bitcnt;

   always_comb begin
      adj = scratch;
      for (int d = 0; d < DIGITS; d++)
         if (scratch[4*d +: 4] >= 4'd5) adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
   end

   assign next_scratch = {adj[SW-2:0], shreg[WIDTH-1]};

   // BCD is only written from a finished conversion, so it never shows a partial image
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state   <= IDLE;
         snap    <= '0;
         shreg   <= '0;
         scratch <= '0;
         bitcnt  <= '0;
         BCD     <= '0;
      end else if (OUT != snap) begin
         state   <= SHIFT;
         snap    <= OUT;
         shreg   <= OUT;
         scratch <= '0;
         bitcnt  <= CW'(WIDTH);
      end else if (state == SHIFT) begin
         shreg   <= shreg << 1;
         scratch <= next_scratch;
         bitcnt  <= bitcnt - 1'b1;
         if (bitcnt == CW'(1)) begin
            BCD   <= next_scratch;
            state <= IDLE;
         end
      end
   end

   assign BCD_VALID = (state == IDLE) && (OUT == snap);
`else
   assign BCD       = '0;
   assign BCD_VALID = 1'b0;
`endif

endmodule

// File: tb/tb_updown_tick_counter.sv
// Bench for updown_tick_counter: directed vector table, then random stimulus vs. a behavioural model.
module tb_updown_tick_counter;
   localparam int WIDTH = 8, MAX = 199, DIV = 12, DIGITS = 3;
`ifdef COUNTER_BCD_EN
   localparam bit BCD_ON = 1'b1;
`else
   localparam bit BCD_ON = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst, en, dir, load;
   logic [WIDTH-1:0]    load_val;
   logic [WIDTH-1:0]    out;
   logic                tick, tc;
   logic [4*DIGITS-1:0] bcd;
   logic                bcd_valid;

   updown_tick_counter #(.WIDTH(WIDTH), .MAX(MAX), .DIV(DIV), .DIGITS(DIGITS)) dut (
      .CLK(clk), .RST(rst), .EN(en), .DIR(dir), .LOAD(load), .LOAD_VAL(load_val),
      .OUT(out), .TICK(tick), .TC(tc), .BCD(bcd), .BCD_VALID(bcd_valid)
   );

   always #5 clk = ~clk;

   int nerr = 0, nchk = 0;

   // behavioural model: integer count, prescaler phase, and time of the last OUT change
   int m_pc = 0, m_out = 0, m_tc = 0, last_chg = 0, ecyc = 0;
   bit vsr = 1'b0;
   bit seen [0:255];

   function automatic int to_bcd(int v);
      int r = 0, p = 1;
      for (int i = 0; i < DIGITS; i++) begin
         r = r | (((v / p) % 10) << (4 * i));
         p = p * 10;
      end
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at edge %0d", name, act, act, exp, exp, ecyc);
      end
   endtask

   task automatic model_step(input bit r, input bit ld, input int lv, input bit e, input bit d);
      bit t;
      int old;
      t   = (m_pc == DIV - 1);
      old = m_out;
      ecyc++;
      if (!r) begin
         m_pc  = 0;
         m_tc  = 0;
         m_out = d ? MAX : 0;
         for (int i = 0; i < 256; i++) seen[i] = 1'b0;
         seen[0]  = 1'b1;
         vsr      = (m_out == 0);
         last_chg = ecyc;
      end else begin
         m_pc = (m_pc + 1) % DIV;
         m_tc = 0;
         if (ld) m_out = (lv > MAX) ? MAX : lv;
         else if (t && e) begin
            if (!d) begin
               if (m_out == MAX) begin m_out = 0; m_tc = 1; end
               else m_out = m_out + 1;
            end else begin
               if (m_out == 0) begin m_out = MAX; m_tc = 1; end
               else m_out = m_out - 1;
            end
         end
         if (m_out != old) begin
            last_chg = ecyc;
            vsr      = 1'b0;
         end
      end
      seen[m_out] = 1'b1;
   endtask

   task automatic step(input bit r, input bit ld, input int lv, input bit e, input bit d);
      bit ev;
      int ok;
      rst = r; load = ld; load_val = WIDTH'(lv); en = e; dir = d;
      @(posedge clk);
      model_step(r, ld, lv, e, d);
      #1;
      chk("out", int'(out), m_out);
      chk("tc", int'(tc), m_tc);
      chk("tick", int'(tick), int'(m_pc == DIV - 1));
      if (BCD_ON) begin
         ev = vsr || (ecyc - last_chg >= WIDTH + 1);
         chk("bcd_valid", int'(bcd_valid), int'(ev));
         if (ev) chk("bcd", int'(bcd), to_bcd(m_out));
         else begin
            ok = 0;
            for (int v = 0; v < 256; v++) if (seen[v] && to_bcd(v) == int'(bcd)) ok = 1;
            chk("bcd_complete", ok, 1);
         end
      end else begin
         chk("bcd_off", int'(bcd), 0);
         chk("bcd_valid_off", int'(bcd_valid), 0);
      end
   endtask

   typedef struct {
      int n; bit r; bit ld; int lv; bit e; bit d;
      int eo; int etc; int etk; int eb; int ev;
   } vec_t;

   function automatic vec_t mk(int n, bit r, bit ld, int lv, bit e, bit d,
                               int eo, int etc, int etk, int eb, int ev);
      vec_t x;
      x.n = n; x.r = r; x.ld = ld; x.lv = lv; x.e = e; x.d = d;
      x.eo = eo; x.etc = etc; x.etk = etk; x.eb = eb; x.ev = ev;
      return x;
   endfunction

   vec_t tbl[$];

   initial begin
      rst = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; dir = 1'b0;
      //            n  r ld  lv  e d   out tc tk   bcd  vld
      tbl.push_back(mk( 2,0,0,  0,0,0,    0, 0, 0, 'h000,  1));
      tbl.push_back(mk(11,1,0,  0,1,0,    0, 0, 1,    -1, -1));
      tbl.push_back(mk( 1,1,0,  0,1,0,    1, 0, 0,    -1, -1));
      tbl.push_back(mk( 1,1,1,198,1,0,  198, 0, 0,    -1, -1));
      tbl.push_back(mk(10,1,0,  0,1,0,  198, 0, 1,    -1, -1));
      tbl.push_back(mk( 1,1,0,  0,1,0,  199, 0, 0,    -1,  0));
      tbl.push_back(mk( 9,1,0,  0,1,0,  199, 0, 0, 'h199,  1));
      tbl.push_back(mk( 2,1,0,  0,1,0,  199, 0, 1,    -1, -1));
      tbl.push_back(mk( 1,1,0,  0,1,0,    0, 1, 0,    -1, -1));
      tbl.push_back(mk( 1,1,0,  0,1,0,    0, 0, 0,    -1, -1));
      tbl.push_back(mk(10,1,0,  0,1,1,    0, 0, 1,    -1, -1));
      tbl.push_back(mk( 1,1,0,  0,1,1,  199, 1, 0,    -1, -1));
      tbl.push_back(mk( 1,1,0,  0,1,1,  199, 0, 0,    -1, -1));
      tbl.push_back(mk( 1,0,0,  0,0,1,  199, 0, 0, 'h000,  0));
      tbl.push_back(mk( 9,1,0,  0,0,1,  199, 0, 0, 'h199,  1));
      tbl.push_back(mk( 1,1,1,250,0,1,  199, 0, 0,    -1,  1));
      tbl.push_back(mk( 1,1,0,  0,1,1,  199, 0, 1,    -1, -1));
      tbl.push_back(mk( 1,1,1,100,1,1,  100, 0, 0,    -1,  0));
      tbl.push_back(mk(60,1,0,  0,0,1,  100, 0, 0, 'h100,  1));
      tbl.push_back(mk( 6,1,0,  0,1,0,  100, 0, 0,    -1, -1));
      tbl.push_back(mk( 6,1,0,  0,1,1,   99, 0, 0,    -1, -1));
      tbl.push_back(mk(12,1,0,  0,1,0,  100, 0, 0,    -1,  0));
      tbl.push_back(mk( 3,1,0,  0,0,0,  100, 0, 0, 'h099,  0));
      tbl.push_back(mk( 1,1,1, 57,0,0,   57, 0, 0, 'h099,  0));
      tbl.push_back(mk( 8,1,0,  0,0,0,   57, 0, 0, 'h099,  0));
      tbl.push_back(mk( 1,1,0,  0,0,0,   57, 0, 0, 'h057,  1));

      foreach (tbl[k]) begin
         for (int c = 0; c < tbl[k].n; c++)
            step(tbl[k].r, tbl[k].ld, tbl[k].lv, tbl[k].e, tbl[k].d);
         if (tbl[k].eo  >= 0) chk($sformatf("vec%0d_out", k),  int'(out),  tbl[k].eo);
         if (tbl[k].etc >= 0) chk($sformatf("vec%0d_tc", k),   int'(tc),   tbl[k].etc);
         if (tbl[k].etk >= 0) chk($sformatf("vec%0d_tick", k), int'(tick), tbl[k].etk);
         if (BCD_ON && tbl[k].eb >= 0) chk($sformatf("vec%0d_bcd", k), int'(bcd), tbl[k].eb);
         if (BCD_ON && tbl[k].ev >= 0) chk($sformatf("vec%0d_bcd_valid", k), int'(bcd_valid), tbl[k].ev);
      end

      // randomized phase
      begin
         bit d = 1'b0;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) d = ~d;
            step(($urandom_range(149) != 0), ($urandom_range(11) == 0),
                 int'($urandom_range(255)), ($urandom_range(3) != 0), d);
         end
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
